csr_counter_bank: RTL and testbench
===================================

// Module: csr_counter_bank
// PURPOSE
//  Parametrised Zicntr/Zihpm counter file. Holds cycle, time and instret plus NUM_HPM
//  event-programmable hpmcounters, with machine-level write, inhibit and user-access
//  control. Sits beside the main CSR decode; it serves every CSR address in its range
//  and reports illegal accesses.
// PARAMETERS
//  XLEN        32  CSR data width
//  CNT_WIDTH   64  counter width, 33..64; bits above CNT_WIDTH read as zero
//  NUM_HPM      4  hpmcounters implemented (3..3+NUM_HPM-1), 0..29
//  NUM_EVENTS   8  width of event_valid bus
// PORTS
//  clock                    in   1           rising-edge clock
//  reset                    in   1           asynchronous, active-low reset
//  instr_retired            in   1           one instruction retired this cycle
//  time_tick                in   1           increment time counter this cycle
//  event_valid              in   NUM_EVENTS  per-cycle event pulses
//  priv_mode                in   2           00 U, 01 S, 11 M
//  csr_addr                 in   12          CSR address
//  read_csr                 in   1           read access this cycle
//  write_csr                in   1           write access this cycle
//  write_function           in   2           01 RW, 10 RS (set), 11 RC (clear)
//  write_value              in   XLEN        write operand
//  read_value               out  XLEN        old CSR value, combinational
//  illegal_instr_exception  out  1           access illegal, combinational
// BEHAVIOUR
//  Reset: all counters, mcounteren, mcountinhibit, mhpmevent* = 0; outputs 0 when idle.
//  Map: C00/C01/C02 cycle/time/instret (U-view), C03+k hpmcounter; C80+ = high halves.
//   B00/B02 mcycle/minstret, B03+k mhpmcounter, B80+ high halves; 306 mcounteren,
//   320 mcountinhibit (bits 0,2,3+k writable, others read 0), 323+k mhpmevent.
//  Read: read_value = selected value when read_csr and legal, else 0. Same cycle, no state.
//  Legality: any unmapped address -> illegal. Cxx write -> illegal. Bxx/3xx access needs
//   priv 11. Cxx read in U/S needs mcounteren[addr[4:0]]; M always allowed.
//   Illegal access: no state update, read_value = 0.
//  Write (posedge, legal only): new = RW wv | RS old|wv | RC old&~wv. Low half write keeps
//   high half and vice versa; no carry between halves on write.
//  Increment per cycle, modulo 2^CNT_WIDTH: cycle +1 unless inhibit[0]; instret
//   +instr_retired unless inhibit[2]; time +time_tick (never inhibited, not writable);
//   hpm k +event_valid[ev-1] when mhpmevent_k = ev in 1..NUM_EVENTS and !inhibit[3+k];
//   ev 0 or > NUM_EVENTS -> never counts. mhpmevent keeps low 5 bits only.
//  Write to a counter half in the same cycle as its increment: written value wins,
//   increment of that cycle dropped (both halves).
//  read_csr and write_csr together: read_value shows pre-write value.
//  Reset asserted mid-operation clears all state immediately; pending write is lost.
// CONFIGURATION
//  CSR_COUNTER_OVERFLOW_EN: adds output counter_overflow [NUM_HPM], sticky bit k set when
//   hpm k increments from all-ones to zero; cleared by any legal write to either half of
//   that counter (write wins over simultaneous set); reset 0.
//  Without macro: port absent; wrap is silent.
// TESTING
//  Reset then 10 idle cycles, M read B00 -> 10 (±read offset fixed by bench); C02 -> 0.
//  M writes RW B80=0x1, B00=0xFFFFFFFF; next reads B80=0x1, B00=0xFFFFFFFF; one cycle
//   later B00=0, B80=0x2.
//  U read C00 with mcounteren=0 -> illegal=1, read_value=0; set mcounteren=0x1 -> legal.
//  mhpmevent3=2, pulse event_valid[1] 5x, event_valid[0] 3x -> hpmcounter3 = 5.
//  mcountinhibit=0x5 for 20 cycles with instr_retired=1 -> mcycle, minstret unchanged.
//  OVERFLOW_EN: hpm3 preset all-ones, one event -> counter_overflow[0]=1, value 0;
//   write B03 -> flag 0.

Source files
------------

// File: rtl/csr_counter_bank.sv
// csr_counter_bank: Zicntr/Zihpm counter file (cycle/time/instret + NUM_HPM hpm counters) with M-mode control CSRs.
// Latency: read_value/illegal_instr_exception are combinational; writes and increments land on the next clock edge.
// Backpressure: none, every access completes in its cycle. Define CSR_COUNTER_OVERFLOW_EN for sticky per-hpm wrap flags.
module csr_counter_bank #(
    parameter int XLEN       = 32,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_retired,
    input  logic                  time_tick,
    input  logic [NUM_EVENTS-1:0] event_valid,
    input  logic [1:0]            priv_mode,
    input  logic [11:0]           csr_addr,
    input  logic                  read_csr,
    input  logic                  write_csr,
    input  logic [1:0]            write_function,
    input  logic [XLEN-1:0]       write_value,
    output logic [XLEN-1:0]       read_value,
    output logic                  illegal_instr_exception
`ifdef CSR_COUNTER_OVERFLOW_EN
    ,
    output logic [NUM_HPM-1:0]    counter_overflow
`endif
);

    localparam int NCNT   = 3 + NUM_HPM;
    localparam int HPM_N  = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int FULL_W = 2 * XLEN;
    // Implemented inhibit bits: CY, IR and one per hpm counter; TM and the rest read zero.
    localparam logic [31:0] INH_MASK = 32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

    logic [CNT_WIDTH-1:0] cnt_q [NCNT];
    logic [CNT_WIDTH-1:0] cnt_d [NCNT];
    logic [31:0]          mcounteren_q;
    logic [31:0]          mcountinhibit_q;
    logic [4:0]           mhpmevent_q [HPM_N];

    logic [4:0]  idx;
    logic        hi_half;
    logic        idx_cnt;
    logic        idx_hpm;
    logic        sel_ucnt;
    logic        sel_mcnt;
    logic        sel_cen;
    logic        sel_inh;
    logic        sel_evt;
    logic        m_only;
    logic        is_m;
    logic        access;
    logic        illegal;
    logic        legal_wr;

    assign idx     = csr_addr[4:0];
    assign hi_half = csr_addr[7];

    always_comb begin
        idx_cnt = 1'b0;
        for (int i = 0; i < NCNT; i++) begin
            if (idx == 5'(i)) idx_cnt = 1'b1;
        end
    end

    assign idx_hpm  = idx_cnt && (idx >= 5'd3);
    assign sel_ucnt = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00) && idx_cnt;
    // There is no machine-level time alias, so B01/B81 stay unmapped.
    assign sel_mcnt = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00) && idx_cnt && (idx != 5'd1);
    assign sel_cen  = (csr_addr == 12'h306);
    assign sel_inh  = (csr_addr == 12'h320);
    assign sel_evt  = (csr_addr[11:5] == 7'h19) && idx_hpm;

    assign m_only = sel_mcnt | sel_cen | sel_inh | sel_evt;
    assign is_m   = (priv_mode == 2'b11);
    assign access = read_csr | write_csr;

    assign illegal = access && (!(sel_ucnt || m_only)
                             || (sel_ucnt && write_csr)
                             || (m_only && !is_m)
                             || (sel_ucnt && !is_m && !mcounteren_q[idx]));
    assign legal_wr = write_csr && !illegal;

    assign illegal_instr_exception = illegal;

    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [FULL_W-1:0]    sel_full;
    logic [4:0]           sel_evt_val;
    logic [XLEN-1:0]      cur_val;
    logic [XLEN-1:0]      new_val;
    logic [CNT_WIDTH-1:0] wr_merged;

    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (idx == 5'(i)) sel_cnt = cnt_q[i];
        end
        sel_full = FULL_W'(sel_cnt);

        sel_evt_val = '0;
        for (int k = 0; k < NUM_HPM; k++) begin
            if (idx == 5'(k + 3)) sel_evt_val = mhpmevent_q[k];
        end

        cur_val = '0;
        if (sel_ucnt || sel_mcnt) begin
            cur_val = hi_half ? sel_full[FULL_W-1:XLEN] : sel_full[XLEN-1:0];
        end else if (sel_cen) begin
            cur_val = XLEN'(mcounteren_q);
        end else if (sel_inh) begin
            cur_val = XLEN'(mcountinhibit_q);
        end else if (sel_evt) begin
            cur_val = XLEN'(sel_evt_val);
        end
    end

    always_comb begin
        case (write_function)
            2'b01:   new_val = write_value;
            2'b10:   new_val = cur_val | write_value;
            2'b11:   new_val = cur_val & ~write_value;
            default: new_val = cur_val;
        endcase
    end

    assign read_value = (read_csr && !illegal) ? cur_val : '0;

    // A half write never carries into the other half; the untouched half keeps its pre-edge value.
    always_comb begin
        wr_merged = sel_cnt;
        if (hi_half) wr_merged[CNT_WIDTH-1:XLEN] = new_val[CNT_WIDTH-XLEN-1:0];
        else         wr_merged[XLEN-1:0]         = new_val;
    end

    logic [NCNT-1:0] inc;
    logic [NCNT-1:0] wr_cnt;

    always_comb begin
        inc    = '0;
        inc[0] = !mcountinhibit_q[0];
        inc[1] = time_tick;
        inc[2] = instr_retired && !mcountinhibit_q[2];
        for (int k = 0; k < NUM_HPM; k++) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (mhpmevent_q[k] == 5'(e + 1) && event_valid[e]) inc[k + 3] = !mcountinhibit_q[k + 3];
            end
        end

        for (int i = 0; i < NCNT; i++) begin
            wr_cnt[i] = legal_wr && sel_mcnt && (idx == 5'(i));
            if (wr_cnt[i])     cnt_d[i] = wr_merged;
            else if (inc[i])   cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            else               cnt_d[i] = cnt_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
            for (int k = 0; k < HPM_N; k++) mhpmevent_q[k] <= '0;
            mcounteren_q    <= '0;
            mcountinhibit_q <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
            if (legal_wr && sel_cen) mcounteren_q <= 32'(new_val);
            if (legal_wr && sel_inh) mcountinhibit_q <= 32'(new_val) & INH_MASK;
            for (int k = 0; k < NUM_HPM; k++) begin
                if (legal_wr && sel_evt && (idx == 5'(k + 3))) mhpmevent_q[k] <= new_val[4:0];
            end
        end
    end

`ifdef CSR_COUNTER_OVERFLOW_EN
    logic [NUM_HPM-1:0] ovf_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NUM_HPM; k++) begin
                if (wr_cnt[k + 3])                          ovf_q[k] <= 1'b0;
                else if (inc[k + 3] && (&cnt_q[k + 3]))     ovf_q[k] <= 1'b1;
            end
        end
    end

    assign counter_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_csr_counter_bank.sv
// Bench for csr_counter_bank: table-driven CSR map model plus directed literal checks and random traffic.
module tb_csr_counter_bank;

    localparam int XLEN  = 32;
    localparam int CNT_W = 40;
    localparam int NHPM  = 4;
    localparam int NEV   = 8;
    localparam int NCNT  = 3 + NHPM;
    localparam logic [63:0] CMASK = (64'd1 << CNT_W) - 64'd1;

    localparam int K_NONE = 0, K_UCNT = 1, K_MCNT = 2, K_CEN = 3, K_INH = 4, K_EVT = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            instr_retired = 1'b0;
    logic            time_tick = 1'b0;
    logic [NEV-1:0]  event_valid = '0;
    logic [1:0]      priv_mode = 2'b11;
    logic [11:0]     csr_addr = '0;
    logic            read_csr = 1'b0;
    logic            write_csr = 1'b0;
    logic [1:0]      write_function = 2'b01;
    logic [XLEN-1:0] write_value = '0;
    logic [XLEN-1:0] read_value;
    logic            illegal_instr_exception;
`ifdef CSR_COUNTER_OVERFLOW_EN
    logic [NHPM-1:0] counter_overflow;
    logic [NHPM-1:0] ovf_s;
`endif

    always #5 clock = ~clock;

    csr_counter_bank #(.XLEN(XLEN), .CNT_WIDTH(CNT_W), .NUM_HPM(NHPM), .NUM_EVENTS(NEV)) dut (
        .clock(clock),
        .reset(reset),
        .instr_retired(instr_retired),
        .time_tick(time_tick),
        .event_valid(event_valid),
        .priv_mode(priv_mode),
        .csr_addr(csr_addr),
        .read_csr(read_csr),
        .write_csr(write_csr),
        .write_function(write_function),
        .write_value(write_value),
        .read_value(read_value),
        .illegal_instr_exception(illegal_instr_exception)
`ifdef CSR_COUNTER_OVERFLOW_EN
        ,
        .counter_overflow(counter_overflow)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference state: plain integers per architectural register.
    logic [63:0] m_cnt [NCNT];
    logic [31:0] m_cen;
    logic [31:0] m_inh;
    logic [31:0] inh_mask;
    int          m_evt [NHPM];
    bit          m_ovf [NHPM];

    // CSR map as a lookup table: kind, counter slot, high-half flag per address.
    int kind [4096];
    int slot [4096];
    bit half [4096];

    logic [31:0] rd_s;
    logic        ill_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t addr=%h)", name, act, exp, $time, csr_addr);
        end
    endtask

    task automatic build_map();
        for (int a = 0; a < 4096; a++) begin
            kind[a] = K_NONE; slot[a] = 0; half[a] = 0;
        end
        for (int n = 0; n < NCNT; n++) begin
            kind['hC00 + n] = K_UCNT; slot['hC00 + n] = n;
            kind['hC80 + n] = K_UCNT; slot['hC80 + n] = n; half['hC80 + n] = 1;
            if (n != 1) begin
                kind['hB00 + n] = K_MCNT; slot['hB00 + n] = n;
                kind['hB80 + n] = K_MCNT; slot['hB80 + n] = n; half['hB80 + n] = 1;
            end
        end
        kind['h306] = K_CEN;
        kind['h320] = K_INH;
        for (int k = 0; k < NHPM; k++) begin
            kind['h323 + k] = K_EVT; slot['h323 + k] = 3 + k;
        end
        inh_mask = 32'h5;
        for (int k = 0; k < NHPM; k++) inh_mask[3 + k] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCNT; i++) m_cnt[i] = '0;
        for (int k = 0; k < NHPM; k++) begin
            m_evt[k] = 0; m_ovf[k] = 0;
        end
        m_cen = '0;
        m_inh = '0;
    endtask

    function automatic logic [31:0] model_value(input int a);
        int n = slot[a];
        case (kind[a])
            K_UCNT, K_MCNT: return half[a] ? m_cnt[n][63:32] : m_cnt[n][31:0];
            K_CEN:          return m_cen;
            K_INH:          return m_inh;
            K_EVT:          return 32'(m_evt[n - 3]);
            default:        return 32'h0;
        endcase
    endfunction

    function automatic bit model_illegal(input int a);
        if (!(read_csr || write_csr)) return 1'b0;
        case (kind[a])
            K_NONE: return 1'b1;
            K_UCNT: begin
                if (write_csr) return 1'b1;
                if (priv_mode == 2'b11) return 1'b0;
                return !m_cen[slot[a]];
            end
            default: return priv_mode != 2'b11;
        endcase
    endfunction

    // Called at posedge+1 with inputs driven; compares at the negedge, then advances the model one edge.
    task automatic tick();
        int          a;
        bit          exp_ill;
        int          n;
        int          ev;
        logic [31:0] old;
        logic [31:0] nv;
        logic [31:0] exp_rv;
        logic [63:0] nxt [NCNT];
        #4;
        a       = int'(csr_addr);
        exp_ill = model_illegal(a);
        old     = model_value(a);
        exp_rv  = (read_csr && !exp_ill) ? old : 32'h0;
        rd_s    = read_value;
        ill_s   = illegal_instr_exception;
        check("read_value", 64'(rd_s), 64'(exp_rv));
        check("illegal", 64'(ill_s), 64'(exp_ill));
`ifdef CSR_COUNTER_OVERFLOW_EN
        ovf_s = counter_overflow;
        for (int k = 0; k < NHPM; k++) check("counter_overflow", 64'(ovf_s[k]), 64'(m_ovf[k]));
`endif
        if (reset) begin
            for (int i = 0; i < NCNT; i++) nxt[i] = m_cnt[i];
            if (!m_inh[0]) nxt[0] = nxt[0] + 1;
            if (time_tick) nxt[1] = nxt[1] + 1;
            if (instr_retired && !m_inh[2]) nxt[2] = nxt[2] + 1;
            for (int k = 0; k < NHPM; k++) begin
                ev = m_evt[k];
                if (ev >= 1 && ev <= NEV && !m_inh[3 + k] && event_valid[ev - 1]) begin
                    if (m_cnt[3 + k] == CMASK) m_ovf[k] = 1;
                    nxt[3 + k] = nxt[3 + k] + 1;
                end
            end
            for (int i = 0; i < NCNT; i++) nxt[i] = nxt[i] & CMASK;
            if (write_csr && !exp_ill) begin
                case (write_function)
                    2'b01:   nv = write_value;
                    2'b10:   nv = old | write_value;
                    2'b11:   nv = old & ~write_value;
                    default: nv = old;
                endcase
                n = slot[a];
                case (kind[a])
                    K_MCNT: begin
                        if (half[a]) nxt[n] = ({nv, 32'h0} | {32'h0, m_cnt[n][31:0]}) & CMASK;
                        else         nxt[n] = {m_cnt[n][63:32], nv} & CMASK;
                        if (n >= 3) m_ovf[n - 3] = 0;
                    end
                    K_CEN:   m_cen = nv;
                    K_INH:   m_inh = nv & inh_mask;
                    K_EVT:   m_evt[n - 3] = int'(nv & 32'h1F);
                    default: ;
                endcase
            end
            for (int i = 0; i < NCNT; i++) m_cnt[i] = nxt[i];
        end
        @(posedge clock);
        #1;
    endtask

    task automatic acc(input bit rd, input bit wr, input logic [11:0] a, input logic [1:0] fn,
                       input logic [31:0] v, input logic [1:0] pm);
        read_csr = rd; write_csr = wr; csr_addr = a; write_function = fn; write_value = v; priv_mode = pm;
        tick();
        read_csr = 1'b0; write_csr = 1'b0;
    endtask

    task automatic idle(input int n);
        read_csr = 1'b0; write_csr = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [11:0] ra;
        logic [31:0] rv;
        build_map();
        model_reset();
        @(posedge clock);
        #1;

        // Reset state
        idle(1);
        check("reset_rd_idle", 64'(rd_s), 64'h0);
        check("reset_ill_idle", 64'(ill_s), 64'h0);
        acc(1, 0, 12'hB00, 2'b01, 0, 2'b11);
        check("reset_mcycle", 64'(rd_s), 64'h0);

        // Cycle count after 10 idle edges; instret stays zero
        reset = 1'b1;
        idle(10);
        acc(1, 0, 12'hB00, 2'b01, 0, 2'b11);
        check("mcycle_10", 64'(rd_s), 64'd10);
        acc(1, 0, 12'hC02, 2'b01, 0, 2'b11);
        check("instret_0", 64'(rd_s), 64'h0);

        // Half writes and carry from low to high half
        acc(0, 1, 12'hB00, 2'b01, 32'hFFFF_FFFF, 2'b11);
        acc(0, 1, 12'hB80, 2'b01, 32'h1, 2'b11);
        acc(1, 0, 12'hB80, 2'b01, 0, 2'b11);
        check("mcycleh_1", 64'(rd_s), 64'h1);
        acc(1, 0, 12'hB00, 2'b01, 0, 2'b11);
        check("mcycle_wrap", 64'(rd_s), 64'h0);
        acc(1, 0, 12'hB80, 2'b01, 0, 2'b11);
        check("mcycleh_2", 64'(rd_s), 64'h2);

        // User access gated by mcounteren
        acc(1, 0, 12'hC00, 2'b01, 0, 2'b00);
        check("u_cycle_ill", 64'(ill_s), 64'h1);
        check("u_cycle_rd0", 64'(rd_s), 64'h0);
        acc(0, 1, 12'h306, 2'b01, 32'h1, 2'b11);
        acc(1, 0, 12'hC00, 2'b01, 0, 2'b00);
        check("u_cycle_legal", 64'(ill_s), 64'h0);
        acc(1, 0, 12'hC02, 2'b01, 0, 2'b01);
        check("s_instret_ill", 64'(ill_s), 64'h1);
        acc(0, 1, 12'hC00, 2'b01, 0, 2'b11);
        check("m_cxx_write_ill", 64'(ill_s), 64'h1);

        // Event selection: only event index 2 (event_valid[1]) counts
        acc(0, 1, 12'h323, 2'b01, 32'd2, 2'b11);
        event_valid = 8'b10; idle(5);
        event_valid = 8'b01; idle(3);
        event_valid = '0;
        acc(1, 0, 12'hC03, 2'b01, 0, 2'b11);
        check("hpm3_5", 64'(rd_s), 64'd5);
        acc(0, 1, 12'h324, 2'b01, 32'd9, 2'b11);
        event_valid = 8'hFF; idle(3);
        event_valid = '0;
        acc(1, 0, 12'hC04, 2'b01, 0, 2'b11);
        check("hpm4_ev_oob", 64'(rd_s), 64'h0);
        acc(0, 1, 12'h325, 2'b01, 32'h23, 2'b11);
        acc(1, 0, 12'h325, 2'b01, 0, 2'b11);
        check("mhpmevent5_bits", 64'(rd_s), 64'h3);

        // Inhibit cycle and instret
        acc(0, 1, 12'h320, 2'b01, 32'h5, 2'b11);
        acc(0, 1, 12'hB00, 2'b01, 32'h100, 2'b11);
        acc(0, 1, 12'hB02, 2'b01, 32'h200, 2'b11);
        instr_retired = 1'b1;
        idle(20);
        acc(1, 0, 12'hB00, 2'b01, 0, 2'b11);
        check("inh_mcycle", 64'(rd_s), 64'h100);
        acc(1, 0, 12'hB02, 2'b01, 0, 2'b11);
        check("inh_minstret", 64'(rd_s), 64'h200);
        instr_retired = 1'b0;
        acc(0, 1, 12'h320, 2'b10, 32'hFFFF_FFFF, 2'b11);
        acc(1, 0, 12'h320, 2'b01, 0, 2'b11);
        check("inh_mask", 64'(rd_s), 64'h7D);
        acc(0, 1, 12'h320, 2'b11, 32'hFFFF_FFFF, 2'b11);
        acc(1, 0, 12'h320, 2'b01, 0, 2'b11);
        check("inh_clear", 64'(rd_s), 64'h0);

`ifdef CSR_COUNTER_OVERFLOW_EN
        acc(0, 1, 12'hB83, 2'b01, 32'hFF, 2'b11);
        acc(0, 1, 12'hB03, 2'b01, 32'hFFFF_FFFF, 2'b11);
        event_valid = 8'b10; idle(1);
        event_valid = '0;
        acc(1, 0, 12'hC03, 2'b01, 0, 2'b11);
        check("ovf_hpm3_val", 64'(rd_s), 64'h0);
        check("ovf_flag_set", 64'(ovf_s[0]), 64'h1);
        acc(0, 1, 12'hB03, 2'b01, 32'h5, 2'b11);
        idle(1);
        check("ovf_flag_clr", 64'(ovf_s[0]), 64'h0);
`endif

        // Reset mid-operation drops the pending write
        write_csr = 1'b1; csr_addr = 12'hB00; write_function = 2'b01; write_value = 32'h55; priv_mode = 2'b11;
        reset = 1'b0;
        model_reset();
        tick();
        acc(1, 0, 12'hB00, 2'b01, 0, 2'b11);
        check("midreset_mcycle", 64'(rd_s), 64'h0);
        reset = 1'b1;

        // Random traffic
        for (int it = 0; it < 4000; it++) begin
            if (reset == 1'b0) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                model_reset();
            end
            case ($urandom_range(0, 9))
                0:       ra = 12'hC00 + 12'($urandom_range(0, 8));
                1:       ra = 12'hC80 + 12'($urandom_range(0, 8));
                2, 3:    ra = 12'hB00 + 12'($urandom_range(0, 8));
                4:       ra = 12'hB80 + 12'($urandom_range(0, 8));
                5:       ra = 12'h305 + 12'($urandom_range(0, 2));
                6:       ra = 12'h320 + 12'($urandom_range(0, 8));
                7:       ra = 12'($urandom_range(0, 4095));
                default: ra = 12'hC00 + 12'($urandom_range(0, 2));
            endcase
            case ($urandom_range(0, 3))
                0:       rv = $urandom;
                1:       rv = 32'($urandom_range(0, 12));
                2:       rv = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rv = 32'hFF;
            endcase
            instr_retired = 1'($urandom_range(0, 1));
            time_tick     = 1'($urandom_range(0, 1));
            event_valid   = NEV'($urandom);
            read_csr       = ($urandom_range(0, 1) == 1);
            write_csr      = ($urandom_range(0, 4) < 2);
            csr_addr       = ra;
            write_function = 2'($urandom_range(1, 3));
            write_value    = rv;
            priv_mode      = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 2));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
